mult_seq_ctrl: RTL and testbench

- Controller for the shift-add sequential multiplier datapath.
- The datapath is built from enable-gated D flip-flop registers: A (multiplicand), B (multiplier, shift-right), P (partial product, shift-right).
- Sequences the register load, clear, add-enable and shift-enable strobes over N iterations, with a start/busy/done handshake to the top level.
- Owns the iteration counter; the datapath holds no control state.

---
 rtl/mult_seq_ctrl_if.sv | 28 ++
 rtl/mult_seq_ctrl.sv | 89 ++++++++
 tb/tb_mult_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Handshake and strobe bundle between the multiplier controller and its datapath / top level.
// The master side is the controller; the slave side is the datapath plus whoever issues start.
interface mult_seq_ctrl_if #(
   parameter int N = 8
);
   localparam int IW = $clog2(N + 1);

   logic          start;
   logic          q0;
   logic          ld_a;
   logic          ld_b;
   logic          clr_p;
   logic          ld_p;
   logic          sh_en;
   logic          busy;
   logic          done;
   logic [IW-1:0] iter;

   modport master (
      input  start, q0,
      output ld_a, ld_b, clr_p, ld_p, sh_en, busy, done, iter
   );

   modport slave (
      output start, q0,
      input  ld_a, ld_b, clr_p, ld_p, sh_en, busy, done, iter
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Controller for the shift-add sequential multiplier: sequences load/clear/add/shift over N iterations.
// Optional macro MULT_SEQ_CTRL_SKIP_ZERO_EN: a zero multiplier bit shifts directly in the ADD cycle.
module mult_seq_ctrl #(
   parameter int N = 8
) (
   input  logic             clock,
   input  logic             reset,
   mult_seq_ctrl_if.master  bus
);
   localparam int IW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] iter_q;
   logic          load_q;
   logic          add_q;
   logic          shift_q;
   logic          busy_q;
   logic          done_q;
   logic          last_iter;
   logic          skip_now;

   assign last_iter = (iter_q == IW'(N - 1));

   // add_q mirrors state==ADD, so q0 is only ever looked at in the ADD cycle.
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
   assign skip_now = add_q & ~bus.q0;
`else
   assign skip_now = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.start) state_next = S_LOAD;
         S_LOAD:  state_next = S_ADD;
         S_ADD: begin
            if (skip_now) state_next = last_iter ? S_DONE : S_ADD;
            else          state_next = S_SHIFT;
         end
         S_SHIFT: state_next = last_iter ? S_DONE : S_ADD;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they are registered yet line up with the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         iter_q  <= '0;
         load_q  <= 1'b0;
         add_q   <= 1'b0;
         shift_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_LOAD:  iter_q <= '0;
            S_SHIFT: iter_q <= iter_q + IW'(1);
            S_ADD:   if (skip_now) iter_q <= iter_q + IW'(1);
            default: ;
         endcase
         load_q  <= (state_next == S_LOAD);
         add_q   <= (state_next == S_ADD);
         shift_q <= (state_next == S_SHIFT);
         busy_q  <= (state_next != S_IDLE);
         done_q  <= (state_next == S_DONE);
      end
   end

   assign bus.ld_a  = load_q;
   assign bus.ld_b  = load_q;
   assign bus.clr_p = load_q;
   assign bus.ld_p  = add_q & bus.q0;
   assign bus.sh_en = shift_q | skip_now;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.iter  = iter_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a behavioural B register feeds q0, and a scoreboard
// holds the expected multiplier bits and done cycle for every launched multiply.
module tb_mult_seq_ctrl;
   localparam int N  = 8;
   localparam int N2 = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   mult_seq_ctrl_if #(.N(N))  bus8 ();
   mult_seq_ctrl_if #(.N(N2)) bus2 ();

   mult_seq_ctrl #(.N(N))  dut8 (.clock(clock), .reset(reset), .bus(bus8));
   mult_seq_ctrl #(.N(N2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

   logic [N-1:0]  b8, operand8;
   logic [N2-1:0] b2, operand2;

   // Behavioural datapath B registers: load on ld_b, shift right on sh_en.
   always @(posedge clock or posedge reset) begin
      if (reset)            b8 <= '0;
      else if (bus8.ld_b)   b8 <= operand8;
      else if (bus8.sh_en)  b8 <= b8 >> 1;
   end

   always @(posedge clock or posedge reset) begin
      if (reset)            b2 <= '0;
      else if (bus2.ld_b)   b2 <= operand2;
      else if (bus2.sh_en)  b2 <= b2 >> 1;
   end

   assign bus8.q0 = b8[0];
   assign bus2.q0 = b2[0];

   int edge_count = 0;
   always @(posedge clock) edge_count <= edge_count + 1;

   int passed = 0;
   int total  = 0;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      total++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
   endtask

   // Offset from the start-sampling edge to the edge that enters DONE.
   function automatic int done_offset(input int n, input int pop);
`ifdef MULT_SEQ_CTRL_SKIP_ZERO_EN
      return n + pop + 1;
`else
      return 2 * n + 1;
`endif
   endfunction

   bit bit_q[$];
   int done_q[$];

   int   sample_edge;
   int   ld_a_count, first_load_edge, last_load_edge;
   int   sh_count, ld_p_count, done_count, overlap_count;
   logic prev_ld_p = 1'b0;

   // Monitor: each sh_en closes one iteration, whose ld_p sits in the cycle before it.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus8.ld_a) begin
            if (ld_a_count == 0) first_load_edge = edge_count;
            last_load_edge = edge_count;
            ld_a_count++;
         end
         if (bus8.ld_p) ld_p_count++;
         if (bus8.ld_p && bus8.sh_en) overlap_count++;
         if (bus8.sh_en) begin
            sh_count++;
            if (bit_q.size() == 0) checkOutput("sh_en_unexpected", 1, 0);
            else checkOutput("ld_p_iter", int'(prev_ld_p), int'(bit_q.pop_front()));
         end
         if (bus8.done) begin
            done_count++;
            if (done_q.size() == 0) checkOutput("done_unexpected", 1, 0);
            else checkOutput("done_cycle", edge_count, done_q.pop_front());
            checkOutput("iter_at_done", int'(bus8.iter), N);
         end
         prev_ld_p = bus8.ld_p;
      end
   end

   task automatic clear_counts();
      ld_a_count      = 0;
      first_load_edge = -1;
      last_load_edge  = -1;
      sh_count        = 0;
      ld_p_count      = 0;
      done_count      = 0;
      overlap_count   = 0;
   endtask

   task automatic push_expect(input logic [N-1:0] operand, input int s_edge);
      for (int i = 0; i < N; i++) bit_q.push_back(operand[i]);
      done_q.push_back(s_edge + done_offset(N, $countones(operand)));
   endtask

   task automatic applyStimulus(input logic [N-1:0] operand, input bit hold);
      @(negedge clock);
      clear_counts();
      operand8    = operand;
      bus8.start  = 1'b1;
      sample_edge = edge_count + 1;
      push_expect(operand, sample_edge);
      if (!hold) begin
         @(negedge clock);
         bus8.start = 1'b0;
      end
   endtask

   task automatic wait_done(input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (bus8.done) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) checkOutput("done_timeout", 0, 1);
      #1;
   endtask

   task automatic wait_until_edge(input int target);
      for (int i = 0; i < 200 && edge_count < target; i++) @(negedge clock);
   endtask

   int s2, lp2, de2, it2, e_done;
   bit found2;

   initial begin
      bus8.start = 1'b0;
      bus2.start = 1'b0;
      operand8   = '0;
      operand2   = '0;
      clear_counts();

      // Power-on reset
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("idle_busy", int'(bus8.busy), 0);
      checkOutput("idle_iter", int'(bus8.iter), 0);
      checkOutput("idle_done", int'(bus8.done), 0);

      // Basic run, B = 1010_0101
      applyStimulus(8'b1010_0101, 1'b0);
      wait_done(100);
      checkOutput("load_count", ld_a_count, 1);
      checkOutput("load_cycle1", first_load_edge, sample_edge);
      checkOutput("sh_en_count", sh_count, N);
      checkOutput("ld_p_count", ld_p_count, 4);
      checkOutput("ld_p_sh_overlap", overlap_count, 0);
      checkOutput("done_count", done_count, 1);
      @(negedge clock);
      checkOutput("busy_after_done", int'(bus8.busy), 0);

      // Start pulses while busy are ignored
      applyStimulus(8'b1010_0101, 1'b0);
      wait_until_edge(sample_edge + 4);
      bus8.start = 1'b1;
      @(negedge clock);
      bus8.start = 1'b0;
      wait_until_edge(sample_edge + 9);
      bus8.start = 1'b1;
      @(negedge clock);
      bus8.start = 1'b0;
      wait_done(100);
      repeat (4) @(negedge clock);
      checkOutput("busy_rej_loads", ld_a_count, 1);
      checkOutput("busy_rej_dones", done_count, 1);
      checkOutput("busy_rej_idle", int'(bus8.busy), 0);

      // Start held high relaunches right after DONE
      applyStimulus(8'b1010_0101, 1'b1);
      wait_done(100);
      e_done = edge_count;
      push_expect(8'b1010_0101, e_done + 2);
      wait_until_edge(e_done + 2);
      bus8.start = 1'b0;
      #1;
      checkOutput("relaunch_loads", ld_a_count, 2);
      checkOutput("relaunch_cycle20", last_load_edge, sample_edge + 19);
      wait_done(100);
      checkOutput("relaunch_dones", done_count, 2);

      // Asynchronous reset mid-iteration aborts the run
      applyStimulus(8'b1010_0101, 1'b0);
      wait_until_edge(sample_edge + 8);
      #2;
      bus8.start = 1'b1;
      reset      = 1'b1;
      #1;
      checkOutput("reset_outputs", int'({bus8.ld_a, bus8.ld_b, bus8.clr_p, bus8.ld_p,
                                         bus8.sh_en, bus8.busy, bus8.done}), 0);
      checkOutput("reset_iter", int'(bus8.iter), 0);
      repeat (3) @(negedge clock);
      bus8.start = 1'b0;
      reset      = 1'b0;
      bit_q.delete();
      done_q.delete();
      @(negedge clock);
      checkOutput("abort_no_done", done_count, 0);
      checkOutput("abort_busy", int'(bus8.busy), 0);
      checkOutput("abort_iter", int'(bus8.iter), 0);

      applyStimulus(8'h3C, 1'b0);
      wait_done(100);
      checkOutput("post_abort_dones", done_count, 1);
      checkOutput("post_abort_sh_count", sh_count, N);

      // Zero multiplier: no ld_p at all
      applyStimulus(8'h00, 1'b0);
      wait_done(100);
      checkOutput("zero_ld_p_count", ld_p_count, 0);
      checkOutput("zero_sh_count", sh_count, N);
      checkOutput("zero_dones", done_count, 1);

      // Edge width N=2, B=11
      @(negedge clock);
      operand2   = 2'b11;
      bus2.start = 1'b1;
      s2         = edge_count + 1;
      @(negedge clock);
      bus2.start = 1'b0;
      lp2    = 0;
      de2    = -1;
      it2    = -1;
      found2 = 1'b0;
      for (int i = 0; i < 30 && !found2; i++) begin
         if (bus2.ld_p) lp2++;
         if (bus2.done) begin
            found2 = 1'b1;
            de2    = edge_count;
            it2    = int'(bus2.iter);
         end else begin
            @(negedge clock);
         end
      end
      checkOutput("n2_done_seen", int'(found2), 1);
      checkOutput("n2_done_cycle", de2, s2 + done_offset(N2, 2));
      checkOutput("n2_ld_p_count", lp2, 2);
      checkOutput("n2_iter", it2, N2);

      repeat (2) @(negedge clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
